// File: rtl/lcd_msg_writer.sv
// HD44780 16x2 message writer: power-up wait, init commands, then a 34-byte redraw per message request.
// Optional LCD_STARS_EN adds digit_cnt and draws the entered-key stars on line 2 of message 00.
module lcd_msg_writer #(
    parameter int DATA_BITS = 8,
    parameter int T_PWRUP   = 1_000_000,
    parameter int T_EN      = 50,
    parameter int T_CMD     = 2_500,
    parameter int T_CLR     = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           msg_sel,
    input  logic                 msg_req,
`ifdef LCD_STARS_EN
    input  logic [2:0]           digit_cnt,
`endif
    output logic                 ready,
    output logic                 rs,
    output logic                 rw,
    output logic                 enable,
    output logic [DATA_BITS-1:0] data,
    output logic [2:0]           dbg_state
);

    // Handshake: msg_req is a single-cycle pulse qualified by nothing; msg_sel is sampled on
    // that cycle. ready=1 means a request would start a frame on the very next cycle.
    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EN_HI, WAIT} state_t;
    typedef enum logic [1:0] {M_INIT, M_FRAME, M_LINE2} mode_t;

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [31:0] cnt_q, cnt_d, wait_len;
    logic [5:0]  idx_q, idx_d, last_idx;
    logic [1:0]  msg_q, msg_d, pend_msg_q, pend_msg_d;
    logic        pend_q, pend_d, pend_l2_q, pend_l2_d;
    logic        ready_q, rs_q, load, dispatch;
    logic [DATA_BITS-1:0] data_q;
    logic [8:0]  nxt_byte;
    logic [2:0]  stars;
    logic        star_evt;

`ifdef LCD_STARS_EN
    localparam bit STARS_EN = 1'b1;
    logic [2:0] stars_q;

    assign stars    = (digit_cnt > 3'd4) ? 3'd4 : digit_cnt;
    assign star_evt = (stars != stars_q) && (msg_q == 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stars_q <= '0;
        else        stars_q <= stars;
    end
`else
    localparam bit STARS_EN = 1'b0;
    assign stars    = 3'd0;
    assign star_evt = 1'b0;
`endif

    function automatic logic [7:0] line_char(input logic [1:0] msg, input logic line2,
                                             input logic [3:0] col, input logic [2:0] n);
        logic [127:0] txt;
        logic [55:0]  pre;
        pre = "CLAVE: ";
        case ({msg, line2})
            3'b000:  txt = "INGRESE CLAVE:  ";
            3'b001:  txt = {16{8'h20}};
            3'b010:  txt = "CLAVE INCORRECTA";
            3'b011:  txt = "INTENTE DE NUEVO";
            3'b100:  txt = "ACCESO PERMITIDO";
            3'b101:  txt = "PUERTA ABIERTA  ";
            3'b110:  txt = "ALERTA!         ";
            default: txt = "INTRUSO DETECTAD";
        endcase
        line_char = txt[8*(15-int'(col)) +: 8];
        if (STARS_EN && msg == 2'b00 && line2) begin
            if (col < 4'd7)                      line_char = pre[8*(6-int'(col)) +: 8];
            else if (int'(col) < 7 + int'(n))    line_char = 8'h2A;
            else                                 line_char = 8'h20;
        end
    endfunction

    // Returns {rs, byte} for position idx of the current sequence.
    function automatic logic [8:0] seq_byte(input mode_t mode, input logic [5:0] idx,
                                            input logic [1:0] msg, input logic [2:0] n);
        seq_byte = 9'h000;
        case (mode)
            M_INIT: begin
                case (idx[1:0])
                    2'd0:    seq_byte = 9'h038;
                    2'd1:    seq_byte = 9'h00C;
                    2'd2:    seq_byte = 9'h001;
                    default: seq_byte = 9'h006;
                endcase
            end
            M_FRAME: begin
                if (idx == 6'd0)       seq_byte = 9'h080;
                else if (idx <= 6'd16) seq_byte = {1'b1, line_char(msg, 1'b0, 4'(idx - 6'd1), n)};
                else if (idx == 6'd17) seq_byte = 9'h0C0;
                else                   seq_byte = {1'b1, line_char(msg, 1'b1, 4'(idx - 6'd18), n)};
            end
            default: begin
                if (idx == 6'd0) seq_byte = 9'h0C0;
                else             seq_byte = {1'b1, line_char(msg, 1'b1, 4'(idx - 6'd1), n)};
            end
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        idx_d      = idx_q;
        mode_d     = mode_q;
        msg_d      = msg_q;
        pend_d     = pend_q;
        pend_msg_d = pend_msg_q;
        pend_l2_d  = pend_l2_q;
        load       = 1'b0;
        dispatch   = 1'b0;
        wait_len   = (mode_q == M_INIT && idx_q == 6'd2) ? 32'(T_CLR) : 32'(T_CMD);
        case (mode_q)
            M_INIT:  last_idx = 6'd3;
            M_FRAME: last_idx = 6'd33;
            default: last_idx = 6'd16;
        endcase

        // Every request is first captured as pending; a dispatch this cycle consumes it.
        if (msg_req) begin
            pend_d     = 1'b1;
            pend_msg_d = msg_sel;
            pend_l2_d  = 1'b0;
        end else if (star_evt && !pend_q) begin
            pend_d    = 1'b1;
            pend_l2_d = 1'b1;
        end

        case (state_q)
            PWRUP: begin
                if (cnt_q == 32'(T_PWRUP - 1)) begin
                    state_d = INIT;
                    mode_d  = M_INIT;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            INIT, SETUP: begin
                state_d = EN_HI;
                cnt_d   = '0;
            end
            EN_HI: begin
                if (cnt_q == 32'(T_EN - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q == wait_len - 32'd1) begin
                    if (idx_q == last_idx) begin
                        dispatch = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = (mode_q == M_INIT) ? INIT : SETUP;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
            end
            IDLE:    dispatch = 1'b1;
            default: state_d = PWRUP;
        endcase

        if (dispatch) begin
            cnt_d = '0;
            if (pend_d) begin
                state_d = SETUP;
                idx_d   = '0;
                load    = 1'b1;
                pend_d  = 1'b0;
                if (pend_l2_d) begin
                    mode_d = M_LINE2;
                end else begin
                    mode_d = M_FRAME;
                    msg_d  = pend_msg_d;
                end
            end else begin
                state_d = IDLE;
            end
        end

        nxt_byte = seq_byte(mode_d, idx_d, msg_d, stars);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PWRUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            mode_q     <= M_INIT;
            msg_q      <= '0;
            pend_q     <= 1'b0;
            pend_msg_q <= '0;
            pend_l2_q  <= 1'b0;
            ready_q    <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            msg_q      <= msg_d;
            pend_q     <= pend_d;
            pend_msg_q <= pend_msg_d;
            pend_l2_q  <= pend_l2_d;
            ready_q    <= (state_d == IDLE);
            if (load) begin
                rs_q   <= nxt_byte[8];
                data_q <= DATA_BITS'(nxt_byte[7:0]);
            end
        end
    end

    assign ready     = ready_q;
    assign rs        = rs_q;
    assign rw        = 1'b0;
    assign enable    = (state_q == EN_HI);
    assign data      = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Bench for lcd_msg_writer: captures every byte on enable falling edges and compares with
// a string-based model of the init sequence and message frames.
module tb_lcd_msg_writer;

  localparam int T_PWRUP = 100;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 4;
  localparam int T_CLR   = 20;
  localparam int BYTE_T  = 1 + T_EN + T_CMD;
  localparam int INIT_T  = T_PWRUP + 3 * BYTE_T + (1 + T_EN + T_CLR);
  localparam int FRAME_T = 34 * BYTE_T;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] msg_sel = 2'b00;
  logic       msg_req = 1'b0;
  logic       ready, rs, rw, enable;
  logic [7:0] data;
  logic [2:0] dbg_state;
`ifdef LCD_STARS_EN
  logic [2:0] digit_cnt = 3'd0;
`endif

  int checks = 0;
  int errors = 0;
  int stars_n = 0;

  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         width_q[$];
  int         rise_q[$];
  int         cur_w = 0;
  int         rise_cnt = 0;
  int         rw_bad = 0;
  int         cyc = 0;
  logic       en_prev = 1'b0;

  lcd_msg_writer #(
    .DATA_BITS(8), .T_PWRUP(T_PWRUP), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .reset(reset), .msg_sel(msg_sel), .msg_req(msg_req),
`ifdef LCD_STARS_EN
    .digit_cnt(digit_cnt),
`endif
    .ready(ready), .rs(rs), .rw(rw), .enable(enable), .data(data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bus monitor: the LCD latches on the falling edge of enable
  always @(negedge clk) begin
    cyc++;
    if (rw !== 1'b0) rw_bad++;
    if (enable === 1'b1) begin
      if (en_prev !== 1'b1) begin
        cur_w = 1;
        rise_cnt++;
        rise_q.push_back(cyc);
      end else begin
        cur_w++;
      end
    end else if (en_prev === 1'b1) begin
      cap_q.push_back({rs, data});
      width_q.push_back(cur_w);
    end
    en_prev = enable;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic string line_text(input int msg, input bit line2, input int n);
    string s;
    case (msg * 2 + int'(line2))
      0:       s = "INGRESE CLAVE:  ";
      1:       s = "                ";
      2:       s = "CLAVE INCORRECTA";
      3:       s = "INTENTE DE NUEVO";
      4:       s = "ACCESO PERMITIDO";
      5:       s = "PUERTA ABIERTA  ";
      6:       s = "ALERTA!         ";
      default: s = "INTRUSO DETECTAD";
    endcase
`ifdef LCD_STARS_EN
    if (msg == 0 && line2) begin
      s = "CLAVE: ";
      for (int i = 0; i < ((n > 4) ? 4 : n); i++) s = {s, "*"};
      while (s.len() < 16) s = {s, " "};
    end
`endif
    return s;
  endfunction

  task automatic push_text(input string s);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[i]});
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_frame(input int msg);
    exp_q.push_back(9'h080);
    push_text(line_text(msg, 1'b0, stars_n));
    exp_q.push_back(9'h0C0);
    push_text(line_text(msg, 1'b1, stars_n));
  endtask

  task automatic clear_mon();
    cap_q.delete();
    width_q.delete();
    rise_q.delete();
    exp_q.delete();
    rise_cnt = 0;
  endtask

  // scoreboard: byte stream plus enable pulse widths
  task automatic check_stream(input string tag);
    int e0;
    int bad_w;
    e0 = errors;
    bad_w = 0;
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
      if (errors != e0) break;
    end
    foreach (width_q[i]) if (width_q[i] != T_EN) bad_w++;
    check({tag, "_en_width"}, bad_w, 0);
    clear_mon();
  endtask

  // drivers
  task automatic send_req(input logic [1:0] m);
    msg_sel = m;
    msg_req = 1'b1;
    @(negedge clk);
    msg_req = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_init(input string tag);
    int n;
    @(negedge clk);
    clear_mon();
    reset = 1'b1;
    repeat (T_PWRUP) @(negedge clk);
    check({tag, "_pwrup_quiet"}, rise_cnt, 0);
    check({tag, "_pwrup_ready"}, ready, 1'b0);
    wait_ready(2000, n);
    check({tag, "_latency"}, T_PWRUP + n, INIT_T);
    check({tag, "_gap_cmd"}, rise_q[1] - rise_q[0], BYTE_T);
    check({tag, "_gap_clr"}, rise_q[3] - rise_q[2], 1 + T_EN + T_CLR);
    push_init();
    check_stream(tag);
  endtask

  initial begin
    int n;
    int a, b, k, last;

    #1 reset = 1'b0;
    #1;
    check("rst_enable", enable, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_rs", rs, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_ready", ready, 1'b0);
    repeat (3) @(negedge clk);

    run_init("init");

    // single frame, message 10
    send_req(2'b10);
    check("f10_ready_drop", ready, 1'b0);
    wait_ready(2000, n);
    check("f10_latency", n, FRAME_T);
    push_frame(2);
    check_stream("f10");

    // requests during a frame: last one wins, current frame untouched
    send_req(2'b10);
    repeat (30) @(negedge clk);
    send_req(2'b01);
    repeat (40) @(negedge clk);
    send_req(2'b11);
    wait_ready(3 * FRAME_T, n);
    repeat (20) @(negedge clk);
    push_frame(2);
    push_frame(3);
    check_stream("overlap");

    // request on the final WAIT cycle of a frame
    send_req(2'b01);
    repeat (FRAME_T - 1) @(negedge clk);
    send_req(2'b11);
    check("edge_ready_low", ready, 1'b0);
    wait_ready(2 * FRAME_T, n);
    check("edge_latency", n, FRAME_T);
    push_frame(1);
    push_frame(3);
    check_stream("edge");

    // randomized request bursts
    for (int r = 0; r < 5; r++) begin
      a = $urandom_range(0, 3);
      send_req(2'(a));
      k = $urandom_range(0, 3);
      last = a;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        b = $urandom_range(0, 3);
        send_req(2'(b));
        last = b;
      end
      wait_ready(3 * FRAME_T, n);
      if (k == 0) check($sformatf("rand%0d_latency", r), n, FRAME_T);
      push_frame(a);
      if (k > 0) push_frame(last);
      check_stream($sformatf("rand%0d", r));
    end

    // reset in the middle of a frame
    send_req(2'b01);
    n = 0;
    while (cap_q.size() < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_byte10", cap_q.size() >= 10, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_enable", enable, 1'b0);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_rs", rs, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    run_init("reinit");

    // request held during power-up wait
    @(negedge clk);
    reset = 1'b0;
    msg_sel = 2'b00;
    msg_req = 1'b1;
    @(negedge clk);
    clear_mon();
    reset = 1'b1;
    repeat (50) @(negedge clk);
    msg_req = 1'b0;
    check("held_quiet", rise_cnt, 0);
    wait_ready(2000, n);
    check("held_latency", 50 + n, INIT_T + FRAME_T);
    push_init();
    push_frame(0);
    check_stream("held");

`ifdef LCD_STARS_EN
    // digit count change with message 00 latched redraws line 2 only
    digit_cnt = 3'd3;
    stars_n = 3;
    @(negedge clk);
    check("stars_ready_drop", ready, 1'b0);
    wait_ready(2000, n);
    check("stars_latency", n, 17 * BYTE_T);
    exp_q.push_back(9'h0C0);
    push_text(line_text(0, 1'b1, stars_n));
    check_stream("stars");
`endif

    check("rw_low", rw_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
